// File: rtl/bcd_seg_display.sv
// Multiplexed 4-digit 7-segment driver: scans BCD digits with inter-digit blanking gaps.
// seg/an are registered (1 cycle after state); disp_reg loads on any bcd_valid strobe.
module bcd_seg_display #(
   parameter int SLOT_CYCLES = 100000,
   parameter int GAP_CYCLES  = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] bcd_in,
   input  logic        bcd_valid,
   input  logic        lz_en,
   output logic [6:0]  seg,
   output logic [3:0]  an,
   output logic        frame_done
);

   localparam int MAX_CYC = (SLOT_CYCLES > GAP_CYCLES) ? SLOT_CYCLES : GAP_CYCLES;
   localparam int CNT_W   = $clog2(MAX_CYC);
   localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SLOT_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
   localparam logic [6:0] SEG_OFF = 7'b1111111;

   typedef enum logic {GAP, DRIVE} state_t;

   state_t           state_q, state_d;
   logic [1:0]       idx_q, idx_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [15:0]      disp_q, disp_d;
   logic [6:0]       seg_q, seg_d;
   logic [3:0]       an_q, an_d;
   logic             fd_q, fd_d;

   logic [3:0] cur_dig;
   logic [3:0] is_zero, zero_or_minus, blank;

   function automatic logic [6:0] seg_decode(input logic [3:0] d);
      case (d)
         4'h0:    seg_decode = 7'b1000000;
         4'h1:    seg_decode = 7'b1111001;
         4'h2:    seg_decode = 7'b0100100;
         4'h3:    seg_decode = 7'b0110000;
         4'h4:    seg_decode = 7'b0011001;
         4'h5:    seg_decode = 7'b0010010;
         4'h6:    seg_decode = 7'b0000010;
         4'h7:    seg_decode = 7'b1111000;
         4'h8:    seg_decode = 7'b0000000;
         4'h9:    seg_decode = 7'b0010000;
         4'hE:    seg_decode = 7'b0111111;
         default: seg_decode = SEG_OFF;
      endcase
   endfunction

   always_comb begin
      disp_d  = bcd_valid ? bcd_in : disp_q;
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q + 1'b1;
      fd_d    = 1'b0;
      if (state_q == GAP) begin
         if (cnt_q == GAP_LAST) begin
            state_d = DRIVE;
            cnt_d   = '0;
         end
      end else if (cnt_q == SLOT_LAST) begin
         state_d = GAP;
         cnt_d   = '0;
         idx_d   = idx_q + 2'd1;
         fd_d    = (idx_q == 2'd3);
      end

      for (int k = 0; k < 4; k++) begin
         is_zero[k]       = (disp_q[4*k +: 4] == 4'h0);
         zero_or_minus[k] = is_zero[k] || (disp_q[4*k +: 4] == 4'hE);
      end
      // A digit blanks only if everything above it is blank-zero or the minus sign.
      blank[3] = lz_en && is_zero[3];
      blank[2] = lz_en && is_zero[2] && zero_or_minus[3];
      blank[1] = lz_en && is_zero[1] && zero_or_minus[3] && zero_or_minus[2];
      blank[0] = 1'b0;

      case (idx_q)
         2'd0:    cur_dig = disp_q[3:0];
         2'd1:    cur_dig = disp_q[7:4];
         2'd2:    cur_dig = disp_q[11:8];
         default: cur_dig = disp_q[15:12];
      endcase

      if (state_q == GAP) begin
         an_d  = 4'b1111;
         seg_d = SEG_OFF;
      end else begin
         an_d         = 4'b1111;
         an_d[idx_q]  = 1'b0;
         seg_d        = blank[idx_q] ? SEG_OFF : seg_decode(cur_dig);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= GAP;
         idx_q   <= 2'd0;
         cnt_q   <= '0;
         disp_q  <= 16'h0000;
         seg_q   <= SEG_OFF;
         an_q    <= 4'b1111;
         fd_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         disp_q  <= disp_d;
         seg_q   <= seg_d;
         an_q    <= an_d;
         fd_q    <= fd_d;
      end
   end

   assign seg        = seg_q;
   assign an         = an_q;
   assign frame_done = fd_q;

endmodule

// File: tb/tb_bcd_seg_display.sv
// Directed bench for bcd_seg_display with SLOT_CYCLES=4, GAP_CYCLES=2 (24-cycle frame).
module tb_bcd_seg_display;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] bcd_in = 16'h0000;
   logic        bcd_valid = 1'b0;
   logic        lz_en = 1'b0;
   logic [6:0]  seg;
   logic [3:0]  an;
   logic        frame_done;

   int checks = 0;
   int errors = 0;

   localparam logic [6:0] S_OFF = 7'b1111111;
   localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100, S3 = 7'b0110000;
   localparam logic [6:0] S4 = 7'b0011001, S5 = 7'b0010010, S6 = 7'b0000010, S7 = 7'b1111000;
   localparam logic [6:0] S9 = 7'b0010000, S_MIN = 7'b0111111;

   bcd_seg_display #(.SLOT_CYCLES(4), .GAP_CYCLES(2)) dut (
      .clk(clk), .rst_n(rst_n), .bcd_in(bcd_in), .bcd_valid(bcd_valid),
      .lz_en(lz_en), .seg(seg), .an(an), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   // Digit driven on the outputs sampled after edge n since reset release, -1 for gap.
   function automatic int slot_of(input int n);
      int m;
      if (n < 3) return -1;
      m = n - 3;
      if ((m % 6) >= 4) return -1;
      return (m / 6) % 4;
   endfunction

   task automatic do_reset();
      rst_n = 1'b0; bcd_valid = 1'b0; bcd_in = 16'h0000; lz_en = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic run_scan_frame(input string name, input logic [15:0] val, input logic lz,
                                 input logic [6:0] s0, input logic [6:0] s1,
                                 input logic [6:0] s2, input logic [6:0] s3, input int ncyc);
      logic [6:0] exp_seg;
      logic [3:0] exp_an;
      logic       exp_fd;
      int         k;
      do_reset();
      bcd_in = val; bcd_valid = 1'b1; lz_en = lz;
      for (int n = 1; n <= ncyc; n++) begin
         @(posedge clk); #1;
         bcd_valid = 1'b0;
         k = slot_of(n);
         exp_an = 4'b1111;
         case (k)
            0: exp_seg = s0;
            1: exp_seg = s1;
            2: exp_seg = s2;
            3: exp_seg = s3;
            default: exp_seg = S_OFF;
         endcase
         if (k >= 0) exp_an[k] = 1'b0;
         exp_fd = ((n % 24) == 0);
         checks++;
         if (an !== exp_an) begin
            errors++; $display("FAIL %s an n=%0d got %b exp %b", name, n, an, exp_an);
         end
         checks++;
         if (seg !== exp_seg) begin
            errors++; $display("FAIL %s seg n=%0d got %b exp %b", name, n, seg, exp_seg);
         end
         checks++;
         if (frame_done !== exp_fd) begin
            errors++; $display("FAIL %s frame_done n=%0d got %b exp %b", name, n, frame_done, exp_fd);
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({an, seg, frame_done} !== {4'b1111, S_OFF, 1'b0}) begin
         errors++; $display("FAIL reset_hold got %b/%b/%b exp 1111/1111111/0", an, seg, frame_done);
      end
      @(negedge clk); rst_n = 1'b1;
      for (int n = 1; n <= 3; n++) begin
         @(posedge clk); #1;
         checks++;
         if (n < 3 && {an, seg} !== {4'b1111, S_OFF}) begin
            errors++; $display("FAIL reset_gap n=%0d got %b/%b exp 1111/1111111", n, an, seg);
         end else if (n == 3 && {an, seg} !== {4'b1110, S0}) begin
            errors++; $display("FAIL reset_first_digit got %b/%b exp 1110/1000000", an, seg);
         end
      end
   endtask

   task automatic test_basic_scan();
      run_scan_frame("scan_1234", 16'h1234, 1'b0, S4, S3, S2, S1, 50);
   endtask

   task automatic test_leading_zero();
      run_scan_frame("lz_0042_on", 16'h0042, 1'b1, S2, S4, S_OFF, S_OFF, 26);
      run_scan_frame("lz_0042_off", 16'h0042, 1'b0, S2, S4, S0, S0, 26);
   endtask

   task automatic test_minus();
      run_scan_frame("minus_E005", 16'hE005, 1'b1, S5, S_OFF, S_OFF, S_MIN, 26);
   endtask

   task automatic test_mid_slot_update();
      do_reset();
      bcd_in = 16'h1234; bcd_valid = 1'b1;
      for (int n = 1; n <= 15; n++) begin
         @(posedge clk); #1;
         bcd_valid = 1'b0;
         if (n == 10) begin
            bcd_in = 16'h5678; bcd_valid = 1'b1;
         end
         if (n == 11) begin
            checks++;
            if ({an, seg} !== {4'b1101, S3}) begin
               errors++; $display("FAIL mid_old got %b/%b exp 1101/%b", an, seg, S3);
            end
         end
         if (n == 12) begin
            checks++;
            if ({an, seg} !== {4'b1101, S7}) begin
               errors++; $display("FAIL mid_new got %b/%b exp 1101/%b", an, seg, S7);
            end
         end
         if (n == 13 || n == 14) begin
            checks++;
            if (an !== 4'b1111) begin
               errors++; $display("FAIL mid_gap n=%0d got %b exp 1111", n, an);
            end
         end
         if (n == 15) begin
            checks++;
            if ({an, seg} !== {4'b1011, S6}) begin
               errors++; $display("FAIL mid_next got %b/%b exp 1011/%b", an, seg, S6);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      bcd_in = 16'h1111; bcd_valid = 1'b1;
      for (int n = 1; n <= 5; n++) begin
         @(posedge clk); #1;
         if (n == 1) bcd_in = 16'h2222;
         if (n == 2) bcd_in = 16'h0009;
         if (n == 3) begin
            bcd_valid = 1'b0;
            checks++;
            if ({an, seg} !== {4'b1110, S2}) begin
               errors++; $display("FAIL b2b_mid got %b/%b exp 1110/%b", an, seg, S2);
            end
         end
         if (n >= 4) begin
            checks++;
            if ({an, seg} !== {4'b1110, S9}) begin
               errors++; $display("FAIL b2b_last n=%0d got %b/%b exp 1110/%b", n, an, seg, S9);
            end
         end
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      bcd_in = 16'h1234; bcd_valid = 1'b1;
      for (int n = 1; n <= 24; n++) begin
         @(posedge clk); #1;
         bcd_valid = 1'b0;
      end
      checks++;
      if ({an, frame_done} !== {4'b0111, 1'b1}) begin
         errors++; $display("FAIL async_pre got %b/%b exp 0111/1", an, frame_done);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({an, seg, frame_done} !== {4'b1111, S_OFF, 1'b0}) begin
         errors++; $display("FAIL async_now got %b/%b/%b exp 1111/1111111/0", an, seg, frame_done);
      end
      repeat (2) @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      for (int n = 1; n <= 3; n++) begin
         @(posedge clk); #1;
         checks++;
         if (n < 3 && an !== 4'b1111) begin
            errors++; $display("FAIL async_gap n=%0d got %b exp 1111", n, an);
         end else if (n == 3 && {an, seg} !== {4'b1110, S0}) begin
            errors++; $display("FAIL async_restart got %b/%b exp 1110/1000000", an, seg);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic_scan();
      test_leading_zero();
      test_minus();
      test_mid_slot_update();
      test_back_to_back();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
